cpu_vram_arbiter: RTL
=====================

CPU_VRAM_ARBITER -- requirements
Module: cpu_vram_arbiter

Interface
REQ-001 Parameter ACCESS_TICKS, default 2, sets the length of the RAM access window in cen ticks; legal range 1..15.
REQ-002 Parameter TIMEOUT_TICKS, default 255, sets the maximum cen ticks spent waiting for a CPU slot; legal range 1..255.
REQ-003 clk_49m  in  1  system clock; all logic SHALL be clocked on its rising edge only.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 cen  in  1  timing clock enable; one-clk-wide pulse marking each access tick.
REQ-006 mreq_n, rfsh_n, rd_n, wr_n  in  1 each  Z80 bus strobes, active low, already synchronous to clk_49m.
REQ-007 sel_n  in  1  video-side select from the address decoder (A15 region), active low.
REQ-008 cpu_slot  in  1  high when the current cen tick belongs to a CPU-owned video RAM slot.
REQ-009 wait_n  out  1  Z80 WAIT, active low.
REQ-010 ram_en_n  out  1  RAM enable back to the address decoder ENABLE input; low grants CPU access to work/sprite RAM.
REQ-011 ram_we_n  out  1  RAM write strobe, active low.
REQ-012 latch_en  out  1  one-clk pulse capturing RAM read data into the CPU data latch.
REQ-013 busy  out  1  high whenever state is not IDLE.

Function
REQ-014 A request SHALL be sel_n=0 & mreq_n=0 & rfsh_n=1 & (rd_n=0 or wr_n=0), sampled every clk.
REQ-015 States SHALL be IDLE, ARM, ACCESS, DONE; encoding free.
REQ-016 IDLE: on request, next clk -> ARM; wait_n=0 from that clk; tick counter cleared.
REQ-017 ARM: on a clk with cen=1 and cpu_slot=1 -> ACCESS next clk; ram_en_n=0 from that clk; access counter loaded with ACCESS_TICKS.
REQ-018 ARM: each cen=1 with cpu_slot=0 SHALL increment the wait counter (8-bit, saturating); when it reaches TIMEOUT_TICKS, enter ACCESS on the same terms as REQ-017 (forced grant).
REQ-019 ACCESS: ram_en_n=0 and wait_n=0 throughout; ram_we_n=0 throughout iff the cycle was latched as a write on entry to ARM (wr_n=0); rd/wr type SHALL be latched once, not re-sampled.
REQ-020 ACCESS: access counter decrements on each cen=1; on the cen where it goes 1->0, for a read cycle latch_en=1 for exactly that clk; next clk -> DONE.
REQ-021 DONE: ram_en_n=1, ram_we_n=1, wait_n=1; remain until mreq_n=1, then next clk -> IDLE.
REQ-022 Latency: request to wait_n=0 SHALL be exactly 1 clk; ram_en_n=0 SHALL never assert without a preceding ARM clk.
REQ-023 Abort: mreq_n=1 observed in ARM or ACCESS SHALL return to IDLE next clk with all outputs inactive and no latch_en pulse.
REQ-024 rfsh_n=0 SHALL never create a request; refresh cycles pass with outputs inactive.
REQ-025 A request present in the same clk as the IDLE return from DONE SHALL be ignored until IDLE is reached (no back-to-back without mreq_n high).
REQ-026 cpu_slot with cen=0 SHALL be ignored.
REQ-027 ram_we_n=0 SHALL only occur with ram_en_n=0.
REQ-028 All outputs SHALL be registered; no combinational input-to-output path.

Reset
REQ-029 reset=1 SHALL force, on the next clk and regardless of state: IDLE, wait_n=1, ram_en_n=1, ram_we_n=1, latch_en=0, busy=0, counters zero.
REQ-030 Reset mid-ACCESS SHALL not emit latch_en; after reset deasserts, a still-active request SHALL start a fresh cycle from IDLE.

Verification
REQ-031 Read, slot on first cen after ARM, ACCESS_TICKS=2 -> wait_n low 1 clk after request; ram_en_n low for 2 cen ticks; latch_en one pulse on second; wait_n high in DONE.
REQ-032 Write with cpu_slot=0 for 3 cen ticks then 1 -> wait held through 3 ticks; ram_we_n and ram_en_n low together for 2 ticks; latch_en never pulses.
REQ-033 cpu_slot stuck 0, TIMEOUT_TICKS=4 -> forced ACCESS after 4th cen tick in ARM; normal completion.
REQ-034 mreq_n rises during ARM -> IDLE next clk, wait_n=1, ram_en_n never asserted.
REQ-035 rfsh_n=0 with sel_n=0, mreq_n=0 -> busy stays 0, all outputs inactive.
REQ-036 reset pulsed on second ACCESS clk -> all outputs inactive next clk, no latch_en; held request restarts ARM 1 clk after reset release.

Source files
------------

// File: rtl/cpu_vram_arbiter.sv
// Arbitrates Z80 accesses to shared video/work RAM against the video timing slots.
// Holds the CPU in WAIT until a CPU slot (or timeout) grants an access window.
module cpu_vram_arbiter #(
    parameter int ACCESS_TICKS  = 2,
    parameter int TIMEOUT_TICKS = 255
) (
    input  logic clk_49m,
    input  logic reset,
    input  logic cen,
    input  logic mreq_n,
    input  logic rfsh_n,
    input  logic rd_n,
    input  logic wr_n,
    input  logic sel_n,
    input  logic cpu_slot,
    output logic wait_n,
    output logic ram_en_n,
    output logic ram_we_n,
    output logic latch_en,
    output logic busy
);

    typedef enum logic [1:0] {IDLE, ARM, ACCESS, DONE} state_t;

    localparam logic [7:0] TO_LAST  = 8'(TIMEOUT_TICKS - 1);
    localparam logic [3:0] ACC_INIT = 4'(ACCESS_TICKS);

    state_t     state, nxt;
    logic [7:0] wait_cnt, wait_nxt;
    logic [3:0] acc_cnt, acc_nxt;
    logic       wr_q, wr_nxt, latch_nxt;
    logic       req, grant;

    assign req   = ~sel_n & ~mreq_n & rfsh_n & (~rd_n | ~wr_n);
    // The cen that would bring the wait count to TIMEOUT_TICKS grants on its own.
    assign grant = cen & (cpu_slot | (wait_cnt >= TO_LAST));

    always_comb begin
        nxt       = state;
        wait_nxt  = wait_cnt;
        acc_nxt   = acc_cnt;
        wr_nxt    = wr_q;
        latch_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    nxt      = ARM;
                    wait_nxt = 8'd0;
                    wr_nxt   = ~wr_n;
                end
            end
            ARM: begin
                if (mreq_n) begin
                    nxt = IDLE;
                end else if (grant) begin
                    nxt     = ACCESS;
                    acc_nxt = ACC_INIT;
                end else if (cen && wait_cnt != 8'hff) begin
                    wait_nxt = 8'(wait_cnt + 8'd1);
                end
            end
            ACCESS: begin
                if (mreq_n) begin
                    nxt = IDLE;
                end else if (cen) begin
                    acc_nxt = 4'(acc_cnt - 4'd1);
                    if (acc_cnt == 4'd1) begin
                        nxt       = DONE;
                        latch_nxt = ~wr_q;
                    end
                end
            end
            DONE: begin
                if (mreq_n) nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they are flops aligned with state.
    always_ff @(posedge clk_49m) begin
        if (reset) begin
            state    <= IDLE;
            wait_cnt <= 8'd0;
            acc_cnt  <= 4'd0;
            wr_q     <= 1'b0;
            wait_n   <= 1'b1;
            ram_en_n <= 1'b1;
            ram_we_n <= 1'b1;
            latch_en <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= nxt;
            wait_cnt <= wait_nxt;
            acc_cnt  <= acc_nxt;
            wr_q     <= wr_nxt;
            wait_n   <= ~(nxt == ARM || nxt == ACCESS);
            ram_en_n <= ~(nxt == ACCESS);
            ram_we_n <= ~(nxt == ACCESS && wr_nxt);
            latch_en <= latch_nxt;
            busy     <= (nxt != IDLE);
        end
    end

endmodule
